// File: rtl/divider_bus_pkg.sv
// Shared types and constants for the divider byte-bus host: FSM states,
// byte count and byte-lane ordering for the outgoing operands and incoming results.
package divider_bus_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        TX_DRIVE   = 3'd1,
        TX_RELEASE = 3'd2,
        RX_WAIT    = 3'd3,
        RX_ACK     = 3'd4,
        DONE       = 3'd5
    } state_t;

    localparam int unsigned NUM_BYTES = 4;
    localparam logic [1:0]  LAST_IDX  = 2'(NUM_BYTES - 1);

    localparam logic [1:0] LANE_DVD_LO = 2'd0;
    localparam logic [1:0] LANE_DVD_HI = 2'd1;
    localparam logic [1:0] LANE_DVS_LO = 2'd2;
    localparam logic [1:0] LANE_DVS_HI = 2'd3;

    localparam logic [1:0] LANE_QUO_LO = 2'd0;
    localparam logic [1:0] LANE_QUO_HI = 2'd1;
    localparam logic [1:0] LANE_REM_LO = 2'd2;
    localparam logic [1:0] LANE_REM_HI = 2'd3;

    function automatic logic [7:0] tx_byte(input logic [1:0]  idx,
                                           input logic [15:0] dividend,
                                           input logic [15:0] divisor);
        logic [7:0] b;
        case (idx)
            LANE_DVD_LO: b = dividend[7:0];
            LANE_DVD_HI: b = dividend[15:8];
            LANE_DVS_LO: b = divisor[7:0];
            LANE_DVS_HI: b = divisor[15:8];
            default:     b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/divider_bus_host_wait_timer.sv
// Saturating wait counter: flags expiry once it has counted TIMEOUT enabled
// cycles since the last clear. TIMEOUT of zero never expires.
module wait_timer #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] count_r;

    // Wait-cycle counter, held at the limit once reached
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (enable && (count_r != LIMIT)) begin
            count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (TIMEOUT != 32'd0) && (count_r == LIMIT);

endmodule

// File: rtl/divider_bus_host.sv
// Host master for the divider byte bus: serialises a 16-bit dividend/divisor as
// four bytes, collects four result bytes and returns quotient/remainder.
module divider_bus_host
    import divider_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_dividend,
    input  logic [15:0] req_divisor,
    output logic        resp_valid,
    output logic [15:0] resp_quotient,
    output logic [15:0] resp_remainder,
    output logic        resp_error,
    output logic        resp_timeout,
    output logic [7:0]  bus_data_in,
    output logic        bus_dataready,
    input  logic        bus_ready_to_accept,
    input  logic [7:0]  bus_data_out,
    input  logic        bus_out_buff_full,
    output logic        bus_receive_data,
    input  logic        bus_error
);

    state_t      state_r, state_s;
    logic [1:0]  idx_r, idx_s;
    logic [15:0] dividend_r, dividend_s;
    logic [15:0] divisor_r, divisor_s;
    logic [15:0] quotient_s, remainder_s;
    logic [7:0]  data_in_s;
    logic        error_s, timeout_s;
    logic        waiting_s, timer_clear_s, expired_s;

    assign waiting_s     = (state_r == TX_DRIVE) || (state_r == TX_RELEASE) ||
                           (state_r == RX_WAIT)  || (state_r == RX_ACK);
    assign timer_clear_s = (state_s != state_r) || !waiting_s;

    wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear_s),
        .enable  (waiting_s),
        .expired (expired_s)
    );

    // Next-state and datapath update; a timeout takes priority over any handshake
    always_comb begin
        state_s     = state_r;
        idx_s       = idx_r;
        dividend_s  = dividend_r;
        divisor_s   = divisor_r;
        quotient_s  = resp_quotient;
        remainder_s = resp_remainder;
        error_s     = resp_error;
        timeout_s   = resp_timeout;
        data_in_s   = bus_data_in;

        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    dividend_s = req_dividend;
                    divisor_s  = req_divisor;
                    idx_s      = 2'd0;
                    error_s    = 1'b0;
                    timeout_s  = 1'b0;
                    state_s    = TX_DRIVE;
                end else begin
                    state_s = IDLE;
                end
            end
            TX_DRIVE: begin
                if (expired_s) begin
                    timeout_s = 1'b1;
                    state_s   = DONE;
                end else if (bus_ready_to_accept) begin
                    state_s = TX_RELEASE;
                end else begin
                    state_s = TX_DRIVE;
                end
            end
            TX_RELEASE: begin
                if (expired_s) begin
                    timeout_s = 1'b1;
                    state_s   = DONE;
                end else if (!bus_ready_to_accept) begin
                    if (idx_r == LAST_IDX) begin
                        idx_s   = 2'd0;
                        state_s = RX_WAIT;
                    end else begin
                        idx_s   = idx_r + 2'd1;
                        state_s = TX_DRIVE;
                    end
                end else begin
                    state_s = TX_RELEASE;
                end
            end
            RX_WAIT: begin
                if (expired_s) begin
                    timeout_s = 1'b1;
                    state_s   = DONE;
                end else if (divisor_r == 16'd0) begin
                    // Device signals divide-by-zero instead of returning bytes
                    if (bus_error) begin
                        error_s     = 1'b1;
                        quotient_s  = 16'd0;
                        remainder_s = 16'd0;
                        state_s     = DONE;
                    end else begin
                        state_s = RX_WAIT;
                    end
                end else if (bus_out_buff_full) begin
                    case (idx_r)
                        LANE_QUO_LO: quotient_s[7:0]   = bus_data_out;
                        LANE_QUO_HI: quotient_s[15:8]  = bus_data_out;
                        LANE_REM_LO: remainder_s[7:0]  = bus_data_out;
                        LANE_REM_HI: remainder_s[15:8] = bus_data_out;
                        default:     quotient_s        = resp_quotient;
                    endcase
                    state_s = RX_ACK;
                end else begin
                    state_s = RX_WAIT;
                end
            end
            RX_ACK: begin
                if (expired_s) begin
                    timeout_s = 1'b1;
                    state_s   = DONE;
                end else if (!bus_out_buff_full) begin
                    if (idx_r == LAST_IDX) begin
                        state_s = DONE;
                    end else begin
                        idx_s   = idx_r + 2'd1;
                        state_s = RX_WAIT;
                    end
                end else begin
                    state_s = RX_ACK;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase

        if (state_s == TX_DRIVE) begin
            data_in_s = tx_byte(idx_s, dividend_s, divisor_s);
        end else begin
            data_in_s = bus_data_in;
        end
    end

    // State, operand and registered output update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r          <= IDLE;
            idx_r            <= 2'd0;
            dividend_r       <= 16'd0;
            divisor_r        <= 16'd0;
            resp_valid       <= 1'b0;
            resp_quotient    <= 16'd0;
            resp_remainder   <= 16'd0;
            resp_error       <= 1'b0;
            resp_timeout     <= 1'b0;
            bus_data_in      <= 8'd0;
            bus_dataready    <= 1'b0;
            bus_receive_data <= 1'b0;
        end else begin
            state_r          <= state_s;
            idx_r            <= idx_s;
            dividend_r       <= dividend_s;
            divisor_r        <= divisor_s;
            resp_valid       <= (state_s == DONE);
            resp_quotient    <= quotient_s;
            resp_remainder   <= remainder_s;
            resp_error       <= error_s;
            resp_timeout     <= timeout_s;
            bus_data_in      <= data_in_s;
            bus_dataready    <= (state_s == TX_DRIVE);
            bus_receive_data <= (state_s == RX_ACK);
        end
    end

    assign req_ready = (state_r == IDLE);

endmodule

// File: tb/tb_divider_bus_host.sv
// Directed bench for divider_bus_host with a behavioural divider-system responder
// and a second instance whose device never answers.
module tb_divider_bus_host;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [15:0] req_dividend = 16'd0;
    logic [15:0] req_divisor = 16'd0;
    logic        req_ready, resp_valid, resp_error, resp_timeout;
    logic [15:0] resp_quotient, resp_remainder;
    logic [7:0]  bus_data_in;
    logic        bus_dataready, bus_receive_data;
    logic        rta, obf, berr;
    logic [7:0]  dout;

    logic        s_req_valid = 1'b0;
    logic        s_req_ready, s_resp_valid, s_resp_error, s_resp_timeout;
    logic [15:0] s_resp_quotient, s_resp_remainder;
    logic [7:0]  s_bus_data_in;
    logic        s_bus_dataready, s_bus_receive_data;

    int checks = 0;
    int errors = 0;
    int resp_cnt = 0;
    int recv_cnt = 0;

    always #5 clk = ~clk;

    divider_bus_host #(.TIMEOUT(1024)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dividend(req_dividend), .req_divisor(req_divisor),
        .resp_valid(resp_valid), .resp_quotient(resp_quotient),
        .resp_remainder(resp_remainder), .resp_error(resp_error),
        .resp_timeout(resp_timeout),
        .bus_data_in(bus_data_in), .bus_dataready(bus_dataready),
        .bus_ready_to_accept(rta), .bus_data_out(dout),
        .bus_out_buff_full(obf), .bus_receive_data(bus_receive_data),
        .bus_error(berr)
    );

    divider_bus_host #(.TIMEOUT(16)) dut_silent (
        .clk(clk), .rst(rst),
        .req_valid(s_req_valid), .req_ready(s_req_ready),
        .req_dividend(16'h1111), .req_divisor(16'h0002),
        .resp_valid(s_resp_valid), .resp_quotient(s_resp_quotient),
        .resp_remainder(s_resp_remainder), .resp_error(s_resp_error),
        .resp_timeout(s_resp_timeout),
        .bus_data_in(s_bus_data_in), .bus_dataready(s_bus_dataready),
        .bus_ready_to_accept(1'b0), .bus_data_out(8'h00),
        .bus_out_buff_full(1'b0), .bus_receive_data(s_bus_receive_data),
        .bus_error(1'b0)
    );

    // Behavioural divider system on the byte bus
    typedef enum logic [2:0] {R_RX, R_CALC, R_ERR, R_SEND, R_ACKW, R_RELW} rsp_t;
    rsp_t        rs;
    logic [7:0]  rx_bytes [4];
    logic [1:0]  rcnt, scnt;
    logic [2:0]  wcnt;
    logic [31:0] res_r;
    logic [15:0] rx_dvd, rx_dvs;
    assign rx_dvd = {rx_bytes[1], rx_bytes[0]};
    assign rx_dvs = {rx_bytes[3], rx_bytes[2]};

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rs <= R_RX; rcnt <= 2'd0; scnt <= 2'd0; wcnt <= 3'd0;
            rta <= 1'b0; obf <= 1'b0; berr <= 1'b0; dout <= 8'd0; res_r <= 32'd0;
        end else begin
            case (rs)
                R_RX: begin
                    if (bus_dataready && !rta) begin
                        rx_bytes[rcnt] <= bus_data_in;
                        rta <= 1'b1;
                    end else if (!bus_dataready && rta) begin
                        rta <= 1'b0;
                        if (rcnt == 2'd3) begin
                            rcnt <= 2'd0; wcnt <= 3'd0; rs <= R_CALC;
                        end else begin
                            rcnt <= rcnt + 2'd1;
                        end
                    end
                end
                R_CALC: begin
                    if (rx_dvs == 16'd0) begin
                        if (wcnt == 3'd4) begin
                            berr <= 1'b1; rs <= R_ERR;
                        end else begin
                            wcnt <= wcnt + 3'd1;
                        end
                    end else begin
                        res_r <= {rx_dvd % rx_dvs, rx_dvd / rx_dvs};
                        scnt <= 2'd0; rs <= R_SEND;
                    end
                end
                R_ERR: if (bus_dataready) begin berr <= 1'b0; rs <= R_RX; end
                R_SEND: if (!bus_receive_data) begin
                    obf <= 1'b1; dout <= res_r[scnt*8 +: 8]; rs <= R_ACKW;
                end
                R_ACKW: if (bus_receive_data) begin obf <= 1'b0; rs <= R_RELW; end
                R_RELW: if (!bus_receive_data) begin
                    if (scnt == 2'd3) begin scnt <= 2'd0; rs <= R_RX; end
                    else begin scnt <= scnt + 2'd1; rs <= R_SEND; end
                end
                default: rs <= R_RX;
            endcase
        end
    end

    // Event monitors for pulse/ack counting
    always @(negedge clk) begin
        if (resp_valid) resp_cnt <= resp_cnt + 1;
        if (bus_receive_data) recv_cnt <= recv_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Raise req_valid now and hold until accepted; returns wait cycles before the accepting IDLE cycle
    task automatic do_req(input logic [15:0] dvd, input logic [15:0] dvs, output int waited);
        int k;
        k = 0;
        req_valid = 1'b1; req_dividend = dvd; req_divisor = dvs;
        while (req_ready !== 1'b1 && k < 100) begin @(negedge clk); k++; end
        waited = k;
        @(negedge clk);
        req_valid = 1'b0;
        check("accepted", {31'd0, req_ready}, 32'd0);
    endtask

    task automatic wait_resp(input string tag);
        int k;
        k = 0;
        while (resp_valid !== 1'b1 && k < 3000) begin @(negedge clk); k++; end
        check(tag, {31'd0, resp_valid}, 32'd1);
    endtask

    initial begin
        int w;
        int snap;
        int k;

        #2;
        check("rst_flags", {26'd0, req_ready, resp_valid, resp_error, resp_timeout,
                            bus_dataready, bus_receive_data}, 32'h20);
        check("rst_data", {bus_data_in, resp_quotient, 8'd0}, 32'd0);
        check("rst_rem", {16'd0, resp_remainder}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Normal divide 100 / 7
        snap = resp_cnt;
        do_req(16'd100, 16'd7, w);
        wait_resp("norm_resp");
        check("norm_q", {16'd0, resp_quotient}, 32'd14);
        check("norm_r", {16'd0, resp_remainder}, 32'd2);
        check("norm_flags", {30'd0, resp_error, resp_timeout}, 32'd0);
        check("norm_tx", {rx_bytes[0], rx_bytes[1], rx_bytes[2], rx_bytes[3]}, 32'h64000700);

        // Full range, second request right behind the first response
        @(negedge clk);
        do_req(16'hFFFF, 16'h0001, w);
        wait_resp("full1_resp");
        check("full1_qr", {resp_quotient, resp_remainder}, 32'hFFFF0000);
        do_req(16'h1234, 16'h1235, w);
        check("full2_accept_cycle", w, 32'd1);
        wait_resp("full2_resp");
        check("full2_qr", {resp_quotient, resp_remainder}, 32'h00001234);
        check("full2_tx", {rx_bytes[0], rx_bytes[1], rx_bytes[2], rx_bytes[3]}, 32'h34123512);
        @(negedge clk);
        @(negedge clk);
        check("pulse_count", resp_cnt - snap, 32'd3);

        // Request held high with changing operands while busy
        snap = resp_cnt;
        req_valid = 1'b1; req_dividend = 16'd100; req_divisor = 16'd7;
        @(negedge clk);
        k = 0;
        while (resp_valid !== 1'b1 && k < 3000) begin
            req_dividend = 16'($urandom); req_divisor = 16'($urandom);
            @(negedge clk); k++;
        end
        req_valid = 1'b0;
        check("busy_resp", {31'd0, resp_valid}, 32'd1);
        check("busy_qr", {resp_quotient, resp_remainder}, {16'd14, 16'd2});
        repeat (5) @(negedge clk);
        check("busy_one_pulse", resp_cnt - snap, 32'd1);

        // Divide by zero
        snap = recv_cnt;
        do_req(16'd50, 16'd0, w);
        wait_resp("dz_resp");
        check("dz_flags", {30'd0, resp_error, resp_timeout}, 32'd2);
        check("dz_qr", {resp_quotient, resp_remainder}, 32'd0);
        check("dz_no_recv", recv_cnt - snap, 32'd0);
        @(negedge clk);

        // Reset during RX_ACK of byte 2, then a clean transaction
        do_req(16'd1000, 16'd3, w);
        k = 0;
        while (!(bus_receive_data === 1'b1 && scnt == 2'd2 && rs == R_ACKW) && k < 3000) begin
            @(negedge clk); k++;
        end
        check("rx2_reached", {31'd0, bus_receive_data}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_flags", {26'd0, req_ready, resp_valid, resp_error, resp_timeout,
                                bus_dataready, bus_receive_data}, 32'h20);
        check("mid_rst_data", {8'd0, bus_data_in, resp_quotient}, 32'd0);
        check("mid_rst_rem", {16'd0, resp_remainder}, 32'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        do_req(16'h1234, 16'h0012, w);
        wait_resp("post_rst_resp");
        check("post_rst_qr", {resp_quotient, resp_remainder}, 32'h01020010);

        // Silent responder on the TIMEOUT=16 instance
        s_req_valid = 1'b1;
        @(negedge clk);
        s_req_valid = 1'b0;
        check("silent_drive", {31'd0, s_bus_dataready}, 32'd1);
        k = 0;
        while (s_resp_valid !== 1'b1 && k < 100) begin @(negedge clk); k++; end
        check("silent_latency", k, 32'd17);
        check("silent_flags", {29'd0, s_resp_timeout, s_resp_error, s_bus_dataready}, 32'h4);
        @(negedge clk);
        check("silent_idle", {30'd0, s_resp_valid, s_req_ready}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/divider_bus_host.md
# divider_bus_host

Host-side master for the divider's 8-bit byte bus. It accepts a 16-bit dividend/divisor request on a valid/ready port and serialises it as four bytes over the four-phase `dataready`/`readyToAccept` handshake. It then collects the four result bytes over the four-phase `OutBuffFull`/`receiveData` handshake and returns quotient and remainder on a single-cycle response port. It sits between a system controller or test sequencer and the divider system's byte interface.

## Interface
- `TIMEOUT`, 1024: max cycles spent in any single wait state before abort; 0 disables the timeout.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE.
- `req_dividend` in 16: dividend, sampled on accept.
- `req_divisor` in 16: divisor, sampled on accept.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_quotient` out 16: result quotient, held until next accept.
- `resp_remainder` out 16: result remainder, held until next accept.
- `resp_error` out 1: divide-by-zero reported.
- `resp_timeout` out 1: handshake timed out.
- `bus_data_in` out 8: byte driven to device `Data_in`.
- `bus_dataready` out 1: host byte valid.
- `bus_ready_to_accept` in 1: device capturing byte.
- `bus_data_out` in 8: device result byte.
- `bus_out_buff_full` in 1: device result byte valid.
- `bus_receive_data` out 1: host acknowledges result byte.
- `bus_error` in 1: device divide-by-zero flag.

## Operation
- **States:** IDLE, TX_DRIVE, TX_RELEASE, RX_WAIT, RX_ACK, DONE. A 2-bit byte index `idx` tracks the current byte.
- **TX byte order:** dividend[7:0], dividend[15:8], divisor[7:0], divisor[15:8].
- **RX byte order:** quotient[7:0], quotient[15:8], remainder[7:0], remainder[15:8].
- **IDLE:** on `req_valid & req_ready`:
  - latch operands;
  - clear `idx`, `resp_error` and `resp_timeout`;
  - go to TX_DRIVE.
  - `req_valid` is ignored in every other state.
- **TX_DRIVE:** `bus_dataready`=1 and `bus_data_in`=byte[idx]. When `bus_ready_to_accept` is sampled 1, go to TX_RELEASE.
- **TX_RELEASE:** `bus_dataready`=0 while `bus_data_in` holds byte[idx]; the device may still capture in this state. When `bus_ready_to_accept` is sampled 0:
  - if idx=3, clear idx and go to RX_WAIT;
  - otherwise increment idx and go to TX_DRIVE.
- **RX_WAIT:** `bus_receive_data`=0.
  - Divisor nonzero: when `bus_out_buff_full`=1, capture `bus_data_out` into result byte[idx] and go to RX_ACK. `bus_error` is ignored.
  - Divisor zero: the device never returns data. When `bus_error`=1, set `resp_error`, zero the quotient and remainder, and go to DONE.
- **RX_ACK:** `bus_receive_data`=1. When `bus_out_buff_full` is sampled 0:
  - if idx=3, go to DONE;
  - otherwise increment idx and go to RX_WAIT.
- **DONE:** `resp_valid`=1 for one cycle, then go to IDLE.
- **Timeout:** a wait counter clears on every state change and counts in TX_DRIVE, TX_RELEASE, RX_WAIT and RX_ACK. When the count reaches `TIMEOUT`:
  - set `resp_timeout`;
  - drop `bus_dataready` and `bus_receive_data` immediately;
  - go to DONE.
  - Partial result bytes remain as captured.
- **Reset mid-operation:** returns to IDLE with all outputs at reset values. No bus cleanup cycle is generated.

## Timing
- **Reset values:**
  - `req_ready`=1;
  - `resp_valid`, `resp_error`, `resp_timeout`, `bus_dataready`, `bus_receive_data` = 0;
  - `bus_data_in`, `resp_quotient`, `resp_remainder` = 0.
- All bus and response outputs are registered; `req_ready` decodes from the state register.
- Each device input is sampled at a rising edge. The host reacts one cycle later, so every handshake edge costs at least 1 cycle per phase.
- `bus_data_in` is stable from TX_DRIVE entry until TX_RELEASE exit.
- Minimum latency from accept to `resp_valid`, with a zero-wait responder: 4×(2+1) TX cycles + 4×(2+1) RX cycles + 1 cycle DONE. Divider compute cycles are additional.
- `resp_*` data is valid in the `resp_valid` cycle and stays stable until the next accept.

## Structure
- **Shared package `divider_bus_pkg`:**
  - state enum;
  - byte-count constant 4;
  - byte-lane index constants for the TX/RX ordering.
- **Sub-module `wait_timer`:** parameterised by `TIMEOUT`, counter width `$clog2(TIMEOUT+1)`, with inputs clear/enable and output expired. It is instantiated once.
- The remainder of the block, FSM plus datapath registers, is a single module.

## Test plan
- **Normal divide:** dividend=100, divisor=7 against a behavioural divider-system responder. Expect `resp_valid` once, quotient=14, remainder=2, error=0, timeout=0. Check TX bytes 0x64, 0x00, 0x07, 0x00 in order.
- **Full-range divide:** 0xFFFF/0x0001, then 0x1234/0x1235. Expect q=0xFFFF/r=0x0000, then q=0x0000/r=0x1234. The second request is accepted on the cycle after the first `resp_valid`.
- **Divide by zero:** divisor=0 and the responder raises `bus_error` 5 cycles after the last TX byte. Expect `resp_error`=1, quotient=remainder=0, and `bus_receive_data` never asserted.
- **Silent responder:** `bus_ready_to_accept` tied to 0 with `TIMEOUT`=16. Expect `resp_timeout`=1 with `resp_valid` 17 cycles after TX_DRIVE entry, and `bus_dataready` low in that cycle.
- **Reset mid-RX:** assert `rst` during RX_ACK of byte 2. Expect all outputs at reset values immediately and `req_ready`=1. A subsequent request then completes correctly.
- **Request while busy:** hold `req_valid` high with changing operands during a transaction. Expect only the operands present in IDLE to be used, and exactly one `resp_valid` per accept.
